// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive framer.
package eth_pkg;

    localparam logic [7:0]  SFD           = 8'hD5;
    // Reflected form of 0x04C11DB7; the CRC register shifts toward bit 0.
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Good-frame residue in MSB-first bit order. The reflected register
    // holds it bit-reversed (32'hDEBB20E3), hence bitrev32() at the compare.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_BODY = 3'd2,
        S_END  = 3'd3,
        S_DROP = 3'd4
    } state_e;

    // Bit positions inside the trailing status byte.
    localparam int STS_CRC_ERR = 0;
    localparam int STS_LEN_ERR = 1;
    localparam int STS_ALIGN   = 2;
    localparam int STS_OVF     = 3;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state logic, data consumed LSB first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c_v;

    // Eight serial CRC steps unrolled into one combinational cone.
    always_comb begin
        c_v = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c_v[0] ^ data_i[i]) begin
                c_v = (c_v >> 1) ^ CRC32_POLY;
            end else begin
                c_v = c_v >> 1;
            end
        end
        crc_o = c_v;
    end

endmodule

// File: rtl/my_gray2bin.sv
// Binary-to-Gray converter (the name is historical; the direction is bin -> Gray).
module my_gray2bin #(
    parameter int W = 16
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII/MII receive framer: strips preamble/SFD, assembles bytes, checks FCS
// and length, writes frame bytes plus a status byte into the RX FIFO, and
// exports Gray-coded monitor counters.
module rmii_rx_framer
    import eth_pkg::*;
#(
    parameter int PHY_WIDTH = 2,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 REF_CLK,
    input  logic                 arst_n,
    input  logic                 CRS,
    input  logic [PHY_WIDTH-1:0] RXD,
    input  logic                 fifo_afull,
    output logic [7:0]           fifo_din,
    output logic                 fifo_wren,
    output logic                 fifo_EOD_in,
    output logic [CNT_WIDTH-1:0] succ_rx_count_gray,
    output logic [CNT_WIDTH-1:0] buff_OF_count_gray,
    output logic [CNT_WIDTH-1:0] crc_err_count_gray,
    output logic [CNT_WIDTH-1:0] len_err_count_gray
);

    localparam int                   LANES     = 8 / PHY_WIDTH;
    localparam logic [1:0]           LANE_LAST = 2'(LANES - 1);
    localparam int                   LEN_W     = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0]     LEN_MIN   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]     LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_e               state_q;
    logic [7:0]           sh_q, sh_d;
    logic [1:0]           lane_q;
    logic [31:0]          crc_q, crc_nxt;
    logic [LEN_W-1:0]     len_q;
    logic                 ovf_q, align_q;
    logic [7:0]           din_q;
    logic                 wren_q, eod_q;
    logic [CNT_WIDTH-1:0] succ_q, bof_q, crc_cnt_q, len_cnt_q;
    logic [CNT_WIDTH-1:0] succ_g, bof_g, crc_g, len_g;
    logic [CNT_WIDTH-1:0] succ_gq, bof_gq, crc_gq, len_gq;
    logic                 crc_bad, len_bad;
    logic [7:0]           status;

    // Newest symbol enters at the top so the first wire bit ends up in bit 0.
    assign sh_d = {RXD, sh_q[7:PHY_WIDTH]};

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (sh_q),
        .crc_o  (crc_nxt)
    );

    // Frame verdict; a truncated frame reports only the overflow bit because
    // its length and FCS are meaningless.
    always_comb begin
        crc_bad = (bitrev32(crc_q) != CRC32_RESIDUE);
        len_bad = (len_q < LEN_MIN) || (len_q > LEN_MAX) || align_q;
        status  = 8'h00;
        if (ovf_q) begin
            status[STS_OVF] = 1'b1;
        end else begin
            status[STS_ALIGN]   = align_q;
            status[STS_LEN_ERR] = len_bad;
            status[STS_CRC_ERR] = crc_bad;
        end
    end

    // Receive FSM with registered FIFO outputs and binary counters.
    //  state | meaning
    //  IDLE  | waiting for carrier
    //  PRE   | in preamble, hunting for SFD
    //  BODY  | assembling and writing frame bytes (lane_q==LANE_LAST: sh_q holds a full byte)
    //  END   | writing status byte, bumping one counter (also the illegal-state sink)
    //  DROP  | discarding until carrier drops
    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            sh_q      <= 8'h00;
            lane_q    <= 2'd0;
            crc_q     <= CRC32_INIT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            align_q   <= 1'b0;
            din_q     <= 8'h00;
            wren_q    <= 1'b0;
            eod_q     <= 1'b0;
            succ_q    <= '0;
            bof_q     <= '0;
            crc_cnt_q <= '0;
            len_cnt_q <= '0;
        end else begin
            sh_q   <= sh_d;
            wren_q <= 1'b0;
            eod_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CRS) begin
                        if (fifo_afull) begin
                            bof_q   <= bof_q + CNT_ONE;
                            state_q <= S_DROP;
                        end else begin
                            state_q <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (!CRS) begin
                        state_q <= S_IDLE;
                    end else if (sh_q == SFD) begin
                        state_q <= S_BODY;
                        lane_q  <= 2'd0;
                        crc_q   <= CRC32_INIT;
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                        align_q <= 1'b0;
                    end
                end
                S_BODY: begin
                    lane_q <= (lane_q == LANE_LAST) ? 2'd0 : lane_q + 2'd1;
                    if (lane_q == LANE_LAST) begin
                        if (fifo_afull) begin
                            ovf_q   <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            crc_q <= crc_nxt;
                            if (len_q <= LEN_MAX) begin
                                len_q <= len_q + LEN_W'(1);
                            end
                            if (len_q < LEN_MAX) begin
                                wren_q <= 1'b1;
                                din_q  <= sh_q;
                            end
                            if (!CRS) begin
                                state_q <= S_END;
                            end
                        end
                    end else if (!CRS) begin
                        align_q <= 1'b1;
                        state_q <= S_END;
                    end
                end
                S_DROP: begin
                    if (!CRS) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    wren_q <= 1'b1;
                    eod_q  <= 1'b1;
                    din_q  <= status;
                    if (ovf_q) begin
                        bof_q <= bof_q + CNT_ONE;
                    end else if (len_bad) begin
                        len_cnt_q <= len_cnt_q + CNT_ONE;
                    end else if (crc_bad) begin
                        crc_cnt_q <= crc_cnt_q + CNT_ONE;
                    end else begin
                        succ_q <= succ_q + CNT_ONE;
                    end
                    state_q <= CRS ? S_DROP : S_IDLE;
                end
            endcase
        end
    end

    my_gray2bin #(.W(CNT_WIDTH)) u_g_succ (.bin_i(succ_q),    .gray_o(succ_g));
    my_gray2bin #(.W(CNT_WIDTH)) u_g_bof  (.bin_i(bof_q),     .gray_o(bof_g));
    my_gray2bin #(.W(CNT_WIDTH)) u_g_crc  (.bin_i(crc_cnt_q), .gray_o(crc_g));
    my_gray2bin #(.W(CNT_WIDTH)) u_g_len  (.bin_i(len_cnt_q), .gray_o(len_g));

    // Register the Gray codes so the user domain never sees conversion glitches.
    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            succ_gq <= '0;
            bof_gq  <= '0;
            crc_gq  <= '0;
            len_gq  <= '0;
        end else begin
            succ_gq <= succ_g;
            bof_gq  <= bof_g;
            crc_gq  <= crc_g;
            len_gq  <= len_g;
        end
    end

    assign fifo_din           = din_q;
    assign fifo_wren          = wren_q;
    assign fifo_EOD_in        = eod_q;
    assign succ_rx_count_gray = succ_gq;
    assign buff_OF_count_gray = bof_gq;
    assign crc_err_count_gray = crc_gq;
    assign len_err_count_gray = len_gq;

endmodule
